dc_bitstream_packer: RTL and testbench
======================================

Name: dc_bitstream_packer

Overview:
- Sits directly downstream of the DC-coefficient entropy encoder.
- Consumes variable-length codewords as (codeword bits, length) pairs and packs them MSB-first into a continuous bitstream.
- Emits fixed-width output words over a valid/ready handshake to the slice writer.
- A flush request pads the final partial word with zeros and marks it as the last word.

Parameters:
- OUT_W, 32: output word width in bits.
- MAX_LEN, 24: maximum codeword length in bits; also the input code width.
- ACC_W, OUT_W+MAX_LEN (56): accumulator width, derived; not to be overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword present.
- in_code  in  MAX_LEN  codeword; the valid bits are right-justified (bit in_len-1 is sent first).
- in_len  in  6  codeword length, 0..MAX_LEN.
- in_ready  out  1  packer can accept a codeword or flush this cycle.
- flush  in  1  end-of-stream request; accepted only when in_ready=1.
- out_data  out  OUT_W  packed word; first bitstream bit is in the MSB.
- out_valid  out  1  out_data valid.
- out_last  out  1  qualifies out_data as the final (padded) word of a flush.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- flush_done  out  1  one-cycle pulse: flush complete, packer empty.
- word_count  out  16  words emitted since the last flush_done; wraps modulo 2^16.

Behaviour:
- Reset (async, reset_n=0), all cleared:
  - acc=0, cnt=0, state=RUN.
  - out_data=0, out_valid=0, out_last=0, flush_done=0, word_count=0.
  - in_ready evaluates to 1 once reset is released.
- Reset asserted mid-operation: all partial bits and any pending word are discarded; no flush_done is generated.
- Internal state:
  - acc[ACC_W-1:0] holds cnt valid bits left-justified at the MSB.
  - cnt ranges 0..ACC_W-1.
- Output slot free when out_valid=0, or out_valid=1 and out_ready=1.
- in_ready = (state==RUN) and (cnt < OUT_W). This is combinational from registered state only.
- Accept (in_valid and in_ready):
  - in_code is masked to its low in_len bits; bits above in_len are ignored.
  - The masked code is appended at bit position ACC_W-1-cnt downward; cnt += in_len.
  - in_len=0 is accepted as a no-op.
  - in_len > MAX_LEN is illegal; the bench asserts it never occurs.
- Emit (RUN or FLUSH, cnt >= OUT_W, slot free):
  - out_data <= acc[ACC_W-1 -: OUT_W]; out_valid <= 1; out_last <= 0.
  - acc <<= OUT_W; cnt -= OUT_W; word_count += 1.
- Accept and emit are mutually exclusive in a cycle: accept needs cnt<OUT_W, emit needs cnt>=OUT_W.
  - Sustained rate is one codeword per cycle, plus one drain cycle per word.
- out_valid clears when out_ready=1 and no new word is loaded in the same cycle.
- out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Latency: a codeword accepted at edge k that brings cnt to >= OUT_W gives out_valid=1 after edge k+1, provided the slot is free.
- FSM:
  - RUN:
    - flush and in_ready → FLUSH.
    - If in_valid is also set in that cycle, that codeword is appended first.
  - FLUSH (in_ready=0; in_valid and flush are ignored):
    - cnt >= OUT_W and slot free → normal emit.
    - 0 < cnt < OUT_W and slot free → out_data <= acc top OUT_W bits, with the unused low bits already 0; out_last <= 1; cnt <= 0; word_count += 1.
    - cnt == 0 and (out_valid=0, or out_ready=1 this cycle) → DONE.
  - DONE:
    - flush_done=1 for exactly one cycle; word_count cleared; acc=0.
    - Next state RUN.
- Flush with cnt==0 on entry: no word is emitted and out_last is never set; flush_done follows 2 cycles after flush is accepted.
- Bits are never lost or duplicated under arbitrary out_ready backpressure.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 → out_valid=0, flush_done=0, word_count=0; in_ready=1 after release.
- Eight codewords code=0xA, len=4 on consecutive cycles, out_ready=1 → single word 0xAAAAAAAA, out_valid one cycle after the 8th accept, out_last=0, word_count=1.
- Straddle plus flush:
  - Stimulus: code=0xABCDEF len=24, then code=0x123 len=12, then flush.
  - Words: 0xABCDEF12 (out_last=0), then 0x30000000 (out_last=1).
  - Then flush_done pulse; word_count reads 0 after it.
- Masking: 32× (code=0xFFFFFF, len=1) → 0xFFFFFFFF; then code=0xFFFFFE len=0 ×5 plus 32× (code=0x2, len=1) → 0x00000000.
- Backpressure:
  - Stimulus: out_ready=0 while continuously offering len=24 codewords.
  - in_ready drops once cnt>=32 with a word pending; out_data stays stable.
  - On release, the word sequence matches the bit-exact golden model with no gaps.
- Empty flush and mid-reset:
  - flush with cnt=0 → no out_valid, flush_done exactly 2 cycles later.
  - Separately, assert reset_n with 20 bits buffered → after release, flush yields no word, only flush_done.

Source files
------------

// File: rtl/dc_bitstream_packer.sv
// dc_bitstream_packer
// Packs right-justified variable-length codewords MSB-first into a continuous
// bitstream and emits fixed OUT_W-bit words over a valid/ready handshake.
// A flush pads the final partial word with zeros, tags it out_last, and ends
// with a one-cycle flush_done pulse once the packer is empty.
module dc_bitstream_packer #(
   parameter int OUT_W   = 32,
   parameter int MAX_LEN = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   input  logic [MAX_LEN-1:0] in_code,
   input  logic [5:0]         in_len,
   output logic               in_ready,
   input  logic               flush,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic               flush_done,
   output logic [15:0]        word_count
);

   // Accumulator must hold up to OUT_W-1 pending bits plus one full codeword.
   localparam int ACC_W = OUT_W + MAX_LEN;
   localparam int CNT_W = $clog2(ACC_W + 1);

   localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
   localparam logic [CNT_W:0]   ACC_W_S = (CNT_W + 1)'(ACC_W);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [OUT_W-1:0]   out_data_reg, out_data_next;
   logic               out_valid_reg, out_valid_next;
   logic               out_last_reg, out_last_next;
   logic [15:0]        word_count_reg, word_count_next;

   logic               slot_free;
   logic               accept;
   logic               flush_take;
   logic               emit_full;
   logic               emit_tail;
   logic               enter_done;
   logic [MAX_LEN-1:0] code_masked;
   logic [ACC_W-1:0]   code_ext;
   logic [ACC_W-1:0]   code_aligned;
   logic [CNT_W:0]     shamt;

   // Bits at or above in_len are ignored, so gate each code bit by its index.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
         assign code_masked[gi] = in_code[gi] & (in_len > 6'(gi));
      end
   endgenerate

   assign code_ext  = {{OUT_W{1'b0}}, code_masked};
   // Shift so that code bit in_len-1 lands just below the cnt valid bits.
   assign shamt     = ACC_W_S - {1'b0, cnt_reg} - (CNT_W + 1)'(in_len);
   assign code_aligned = code_ext << shamt;

   assign slot_free  = !out_valid_reg || out_ready;
   assign accept     = in_valid && in_ready;
   assign flush_take = flush && in_ready;
   assign emit_full  = (state_reg != ST_DONE) && (cnt_reg >= OUT_W_C) && slot_free;
   assign emit_tail  = (state_reg == ST_FLUSH) && (cnt_reg != '0) &&
                       (cnt_reg < OUT_W_C) && slot_free;
   assign enter_done = (state_reg == ST_FLUSH) && (cnt_reg == '0) && slot_free;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a flush drains every bit before the done pulse.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:   if (flush_take) state_next = ST_FLUSH;
         ST_FLUSH: if (enter_done) state_next = ST_DONE;
         ST_DONE:  state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   // FSM outputs, decoded from registered state only.
   always_comb begin
      in_ready   = 1'b0;
      flush_done = 1'b0;
      case (state_reg)
         ST_RUN:  in_ready = (cnt_reg < OUT_W_C);
         ST_DONE: flush_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: append a codeword, emit a full word, or emit the padded tail.
   always_comb begin
      acc_next        = acc_reg;
      cnt_next        = cnt_reg;
      out_data_next   = out_data_reg;
      out_valid_next  = out_valid_reg;
      out_last_next   = out_last_reg;
      word_count_next = word_count_reg;

      if (out_ready) begin
         out_valid_next = 1'b0;
         out_last_next  = 1'b0;
      end

      if (accept) begin
         acc_next = acc_reg | code_aligned;
         cnt_next = cnt_reg + CNT_W'(in_len);
      end else if (emit_full) begin
         out_data_next   = acc_reg[ACC_W-1 -: OUT_W];
         out_valid_next  = 1'b1;
         out_last_next   = 1'b0;
         acc_next        = acc_reg << OUT_W;
         cnt_next        = cnt_reg - OUT_W_C;
         word_count_next = word_count_reg + 16'd1;
      end else if (emit_tail) begin
         // Bits below the cnt valid ones are always zero, giving the padding.
         out_data_next   = acc_reg[ACC_W-1 -: OUT_W];
         out_valid_next  = 1'b1;
         out_last_next   = 1'b1;
         acc_next        = '0;
         cnt_next        = '0;
         word_count_next = word_count_reg + 16'd1;
      end else if (enter_done) begin
         acc_next        = '0;
         word_count_next = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_reg        <= '0;
         cnt_reg        <= '0;
         out_data_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         word_count_reg <= '0;
      end else begin
         acc_reg        <= acc_next;
         cnt_reg        <= cnt_next;
         out_data_reg   <= out_data_next;
         out_valid_reg  <= out_valid_next;
         out_last_reg   <= out_last_next;
         word_count_reg <= word_count_next;
      end
   end

   assign out_data   = out_data_reg;
   assign out_valid  = out_valid_reg;
   assign out_last   = out_last_reg;
   assign word_count = word_count_reg;

endmodule

// File: tb/tb_dc_bitstream_packer.sv
// Testbench for dc_bitstream_packer: bit-queue reference model feeding a
// scoreboard of expected words, plus scenario tasks with inline checks.
module tb_dc_bitstream_packer;

   localparam int OUT_W   = 32;
   localparam int MAX_LEN = 24;

   logic               clk       = 1'b0;
   logic               reset_n   = 1'b0;
   logic               in_valid  = 1'b0;
   logic [MAX_LEN-1:0] in_code   = '0;
   logic [5:0]         in_len    = '0;
   logic               flush     = 1'b0;
   logic               out_ready = 1'b1;
   logic               in_ready;
   logic [OUT_W-1:0]   out_data;
   logic               out_valid;
   logic               out_last;
   logic               flush_done;
   logic [15:0]        word_count;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             last;
   } word_t;

   word_t exp_q[$];
   word_t got_q[$];
   bit    bq[$];

   int n_vec = 0;
   int n_err = 0;
   int or_mode = 1;   // 0: hold out_ready low, 1: high, 2: random

   logic             hold_prev = 1'b0;
   logic [OUT_W-1:0] held_data = '0;
   logic             held_last = 1'b0;
   logic [OUT_W-1:0] mw;
   int               mn;
   word_t            e;

   dc_bitstream_packer #(.OUT_W(OUT_W), .MAX_LEN(MAX_LEN)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_code    (in_code),
      .in_len     (in_len),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .flush_done (flush_done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Consumer readiness, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (or_mode == 0)      out_ready = 1'b0;
      else if (or_mode == 1) out_ready = 1'b1;
      else                   out_ready = 1'($urandom_range(0, 1));
   end

   // Mid-cycle monitor: scoreboard compare, hold stability, reference model.
   always @(negedge clk) begin
      if (!reset_n) begin
         bq.delete();
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
               n_err++;
               $display("FAIL hold_stable: got valid=%0b data=%08h last=%0b, required valid=1 data=%08h last=%0b",
                        out_valid, out_data, out_last, held_data, held_last);
            end
         end
         hold_prev = out_valid && !out_ready;
         held_data = out_data;
         held_last = out_last;

         if (out_valid && out_ready) begin
            got_q.push_back(word_t'({out_data, out_last}));
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_word: got data=%08h last=%0b, required no word", out_data, out_last);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.data || out_last !== e.last) begin
                  n_err++;
                  $display("FAIL word: got data=%08h last=%0b, required data=%08h last=%0b",
                           out_data, out_last, e.data, e.last);
               end
               $display("word data=%08h last=%0b", out_data, out_last);
            end
         end

         if (in_ready && in_valid) begin
            assert (in_len <= 6'(MAX_LEN)) else $error("in_len %0d exceeds MAX_LEN", in_len);
            for (int i = int'(in_len) - 1; i >= 0; i--) bq.push_back(in_code[i]);
            while (bq.size() >= OUT_W) begin
               for (int i = 0; i < OUT_W; i++) mw[OUT_W-1-i] = bq.pop_front();
               exp_q.push_back(word_t'({mw, 1'b0}));
            end
         end
         if (in_ready && flush && bq.size() > 0) begin
            mw = '0;
            mn = bq.size();
            for (int i = 0; i < mn; i++) mw[OUT_W-1-i] = bq.pop_front();
            exp_q.push_back(word_t'({mw, 1'b1}));
         end
      end
   end

   // Offer one codeword and hold it until accepted; returns just after the accept edge.
   task automatic drive_code(input logic [MAX_LEN-1:0] c, input logic [5:0] l);
      int t = 0;
      in_valid = 1'b1;
      in_code  = c;
      in_len   = l;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL code_accept: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Request a flush; returns just after the accept edge.
   task automatic drive_flush();
      int t = 0;
      flush = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      n_vec++;
      if (!in_ready) begin
         n_err++;
         $display("FAIL flush_accept: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      end
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   // Wait (bounded) for the flush_done pulse.
   task automatic wait_done(output bit found);
      int t = 0;
      found = 1'b0;
      while (!found && t < 300) begin
         @(negedge clk);
         t++;
         if (flush_done) found = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   // Wait (bounded) until every expected word has been consumed.
   task automatic wait_drain(output bit drained);
      int t = 0;
      drained = 1'b0;
      while (!drained && t < 300) begin
         @(negedge clk);
         t++;
         if (exp_q.size() == 0 && !out_valid) drained = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_code  = 24'h00000A;
      in_len   = 6'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || flush_done !== 1'b0 || word_count !== 16'd0 ||
          out_last !== 1'b0 || out_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got valid=%0b done=%0b wc=%0d last=%0b data=%08h, required all 0",
                  out_valid, flush_done, word_count, out_last, out_data);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset_n  = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit ok;
      got_q.delete();
      for (int i = 0; i < 8; i++) drive_code(24'h00000A, 6'd4);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_latency_early: got out_valid=%0b, required 0", out_valid);
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'hAAAAAAAA || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_word: got valid=%0b data=%08h last=%0b, required valid=1 data=aaaaaaaa last=0",
                  out_valid, out_data, out_last);
      end
      n_vec++;
      if (word_count !== 16'd1) begin
         n_err++;
         $display("FAIL b2b_word_count: got %0d, required 1", word_count);
      end
      wait_drain(ok);
      n_vec++;
      if (!ok || got_q.size() != 1) begin
         n_err++;
         $display("FAIL b2b_drain: drained=%0b words=%0d, required drained=1 words=1", ok, got_q.size());
      end
   endtask

   task automatic test_straddle_flush();
      bit ok;
      got_q.delete();
      drive_code(24'hABCDEF, 6'd24);
      drive_code(24'h000123, 6'd12);
      drive_flush();
      wait_done(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL straddle_done: flush_done not seen, required a pulse");
      end
      n_vec++;
      if (got_q.size() != 2 || got_q[0] !== word_t'({32'hABCDEF12, 1'b0}) ||
          got_q[1] !== word_t'({32'h30000000, 1'b1})) begin
         n_err++;
         $display("FAIL straddle_words: got %0d words, required abcdef12/0 then 30000000/1", got_q.size());
      end
      @(negedge clk);
      n_vec++;
      if (word_count !== 16'd0 || flush_done !== 1'b0) begin
         n_err++;
         $display("FAIL straddle_after: got wc=%0d done=%0b, required wc=0 done=0", word_count, flush_done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_masking();
      bit ok;
      got_q.delete();
      for (int i = 0; i < 32; i++) drive_code(24'hFFFFFF, 6'd1);
      for (int i = 0; i < 5; i++)  drive_code(24'hFFFFFE, 6'd0);
      for (int i = 0; i < 32; i++) drive_code(24'h000002, 6'd1);
      wait_drain(ok);
      n_vec++;
      if (!ok || got_q.size() != 2 || got_q[0] !== word_t'({32'hFFFFFFFF, 1'b0}) ||
          got_q[1] !== word_t'({32'h00000000, 1'b0})) begin
         n_err++;
         $display("FAIL mask_words: drained=%0b words=%0d, required ffffffff then 00000000", ok, got_q.size());
      end
      n_vec++;
      if (word_count !== 16'd2) begin
         n_err++;
         $display("FAIL mask_word_count: got %0d, required 2", word_count);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [OUT_W-1:0] snap;
      or_mode  = 0;
      in_valid = 1'b1;
      in_code  = 24'hC3A5F0;
      in_len   = 6'd24;
      repeat (12) @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_stall: got in_ready=%0b out_valid=%0b, required in_ready=0 out_valid=1",
                  in_ready, out_valid);
      end
      snap = out_data;
      repeat (5) @(negedge clk);
      n_vec++;
      if (out_data !== snap || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_hold: got data=%08h in_ready=%0b, required data=%08h in_ready=0",
                  out_data, in_ready, snap);
      end
      @(posedge clk); #1;
      or_mode = 1;
      drive_code(24'hC3A5F0, 6'd24);
      or_mode = 2;
      for (int i = 0; i < 12; i++) drive_code(24'($urandom), 6'd24);
      for (int i = 0; i < 12; i++) drive_code(24'($urandom), 6'($urandom_range(0, MAX_LEN)));
      or_mode = 1;
      drive_flush();
      wait_done(ok);
      n_vec++;
      if (!ok || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_flush: done=%0b pending=%0d, required done=1 pending=0", ok, exp_q.size());
      end
   endtask

   task automatic test_empty_flush();
      drive_flush();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (flush_done !== (c == 2) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_flush_c%0d: got done=%0b valid=%0b, required done=%0b valid=0",
                     c, flush_done, out_valid, (c == 2));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mid_reset();
      drive_code(24'h0FFFFF, 6'd20);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || flush_done !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_state: got in_ready=%0b valid=%0b done=%0b, required 1/0/0",
                  in_ready, out_valid, flush_done);
      end
      @(posedge clk); #1;
      drive_flush();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (flush_done !== (c == 2) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_flush_c%0d: got done=%0b valid=%0b, required done=%0b valid=0",
                     c, flush_done, out_valid, (c == 2));
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_straddle_flush();
      test_masking();
      test_backpressure();
      test_empty_flush();
      test_mid_reset();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
